// File: rtl/t_bank_arbiter.sv
// t_bank_arbiter: round-robin arbiter and sequencer for a shared bank of
// WIDTH toggle bits. One requester is served at a time in three phases:
// IDLE (select), ISSUE (drive T for one cycle), ACK (complete, advance pointer).
// Every output is decoded from registered state, so req/mask never reach an
// output combinationally.
module t_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] mask,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       t_vec,
    output logic                   busy,
    output logic [WIDTH-1:0]       Q
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [WIDTH-1:0]   mvec_reg, mvec_next;
    logic [WIDTH-1:0]   q_reg, q_next;

    logic [WIDTH-1:0]   mask_arr [N_REQ];
    logic [N_REQ-1:0]   idx_onehot;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    // Unpack the flat mask bus and decode the latched winner into a one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign mask_arr[gi]   = mask[gi*WIDTH +: WIDTH];
            assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(ptr_reg) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: latch winner in IDLE, toggle Q leaving ISSUE, move ptr leaving ACK.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        mvec_next  = mvec_reg;
        q_next     = q_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    idx_next   = win_idx;
                    mvec_next  = mask_arr[win_idx];
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                q_next     = q_reg ^ mvec_reg;
                state_next = ACK;
            end
            ACK: begin
                ptr_next   = idx_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight and clears the bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= IDX_W'(N_REQ - 1);
            idx_reg   <= '0;
            mvec_reg  <= '0;
            q_reg     <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            mvec_reg  <= mvec_next;
            q_reg     <= q_next;
        end
    end

    assign gnt   = (state_reg != IDLE) ? idx_onehot : '0;
    assign ack   = (state_reg == ACK)  ? idx_onehot : '0;
    assign t_vec = (state_reg == ISSUE) ? mvec_reg : '0;
    assign busy  = (state_reg != IDLE);
    assign Q     = q_reg;

endmodule

// File: tb/tb_t_bank_arbiter.sv
// Testbench for t_bank_arbiter: directed stimulus pushes hand-computed
// expectations into a queue; a negedge monitor checks the ISSUE and ACK
// cycles of each operation against the queue head.
module tb_t_bank_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] mask = '0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   t_vec, Q;
    logic           busy;

    t_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .gnt(gnt), .ack(ack), .t_vec(t_vec), .busy(busy), .Q(Q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] mvec;
        logic [7:0] q_before;
        logic [7:0] q_after;
        int         gap;      // expected cycles since previous ack, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_seen = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] mv, input logic [7:0] qb,
                        input logic [7:0] qa, input int gap);
        exp_t e;
        e.idx = idx; e.mvec = mv; e.q_before = qb; e.q_after = qa; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic set_mask(input int i, input logic [7:0] v);
        mask[i*W +: W] = v;
    endtask

    // Monitor: one scoreboard check per ISSUE/ACK cycle, idle outputs checked too.
    int         busy_run = 0;
    int         last_ack = -1;
    logic [N-1:0] prev_ack = '0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
            last_ack = -1;
            prev_ack = '0;
        end else begin
            if (prev_ack != '0) chk("ack_one_cycle", 32'(ack), 32'h0);
            busy_run = busy ? busy_run + 1 : 0;
            if (!busy) begin
                chk("idle_gnt_tvec", {16'h0, 4'h0, gnt, t_vec}, 32'h0);
            end else if (ack == '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 32'(gnt), 32'h0);
                end else begin
                    chk("issue_gnt", 32'(gnt), 32'(1 << exp_q[0].idx));
                    chk("issue_tvec", 32'(t_vec), 32'(exp_q[0].mvec));
                    chk("issue_q", 32'(Q), 32'(exp_q[0].q_before));
                end
            end else begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_vec", 32'(ack), 32'(1 << e.idx));
                    chk("ack_gnt", 32'(gnt), 32'(1 << e.idx));
                    chk("ack_tvec", 32'(t_vec), 32'h0);
                    chk("ack_q", 32'(Q), 32'(e.q_after));
                    chk("busy_len", 32'(busy_run), 32'd2);
                    if (e.gap != 0) chk("grant_gap", 32'(cyc - last_ack), 32'(e.gap));
                end
                last_ack = cyc;
                ack_seen++;
            end
            prev_ack = ack;
        end
    end

    task automatic wait_acks(input int n);
        int target;
        bit done;
        target = ack_seen + n;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk); #1;
            if (ack_seen >= target) done = 1;
        end
        if (!done) chk("ack_timeout", 32'(ack_seen), 32'(target));
    endtask

    task automatic wait_issue();
        bit done;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk); #1;
            if (busy && ack == '0) done = 1;
        end
        if (!done) chk("issue_timeout", 32'(busy), 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_outputs", {gnt, ack, t_vec, 7'h0, busy, Q}, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset with all requesters pending, then continuous round-robin.
        rst = 1'b1;
        req = 4'b1111;
        set_mask(0, 8'h01); set_mask(1, 8'h02); set_mask(2, 8'h04); set_mask(3, 8'h08);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", {gnt, ack, t_vec, 7'h0, busy, Q}, 32'h0);
        push(0, 8'h01, 8'h00, 8'h01, 0);
        push(1, 8'h02, 8'h01, 8'h03, 3);
        push(2, 8'h04, 8'h03, 8'h07, 3);
        push(3, 8'h08, 8'h07, 8'h0F, 3);
        push(0, 8'h01, 8'h0F, 8'h0E, 3);
        @(negedge clk);
        rst = 1'b0;
        wait_acks(5);
        req = '0;
        repeat (3) @(negedge clk);

        // Single toggle, then repeat to restore Q.
        do_reset();
        set_mask(2, 8'hA5);
        push(2, 8'hA5, 8'h00, 8'hA5, 0);
        req = 4'b0100;
        wait_acks(1);
        req = '0;
        push(2, 8'hA5, 8'hA5, 8'h00, 0);
        req = 4'b0100;
        wait_acks(1);
        req = '0;
        repeat (2) @(negedge clk);

        // Late change: mask and req altered during ISSUE must not matter.
        set_mask(1, 8'h3C);
        push(1, 8'h3C, 8'h00, 8'h3C, 0);
        req = 4'b0010;
        wait_issue();
        set_mask(1, 8'hFF);
        req = '0;
        wait_acks(1);
        repeat (3) @(negedge clk);

        // Zero mask: full sequence, Q unchanged.
        set_mask(3, 8'h00);
        push(3, 8'h00, 8'h3C, 8'h3C, 0);
        req = 4'b1000;
        wait_acks(1);
        req = '0;
        repeat (2) @(negedge clk);

        // Reset during ACK: no ack, Q cleared at once, requester 0 wins next.
        do_reset();
        set_mask(0, 8'h55);
        push(0, 8'h55, 8'h00, 8'h55, 0);
        req = 4'b0001;
        wait_acks(1);
        req = '0;
        set_mask(2, 8'hF0);
        push(2, 8'hF0, 8'h55, 8'hA5, 0);
        req = 4'b0100;
        wait_issue();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_q", 32'(Q), 32'h0);
        chk("async_rst_ack_gnt", {24'h0, ack, gnt}, 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        exp_q.delete();
        req = 4'b1111;
        set_mask(0, 8'h11);
        @(negedge clk);
        @(negedge clk);
        push(0, 8'h11, 8'h00, 8'h11, 0);
        rst = 1'b0;
        wait_acks(1);
        req = '0;
        repeat (4) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
